// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path.
//
// Contents:
//   INSTR_W_DEFAULT  default instruction register width
//   CNT_W_DEFAULT    default retired-instruction counter width
//   phase_t          control-phase state encoding
//   strobes_t        one-hot phase strobe bundle
//   phase_decode()   state -> strobe decode, all zero in StIdle
package cpu_pkg;

  localparam int unsigned INSTR_W_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec1,
    StExec2,
    StExec3
  } phase_t;

  typedef struct packed {
    logic fetch;
    logic exec1;
    logic exec2;
    logic exec3;
  } strobes_t;

  function automatic strobes_t phase_decode(input phase_t phase);
    strobes_t s;
    s = '0;
    unique case (phase)
      StFetch: s.fetch = 1'b1;
      StExec1: s.exec1 = 1'b1;
      StExec2: s.exec2 = 1'b1;
      StExec3: s.exec3 = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Bus between the phase sequencer and its surroundings (ROM, decoder, debug).
//
// Signals:
//   run, step        run/single-step control
//   rom_q            fetched instruction word
//   extra, extra2    decoder requests for EXEC2 / EXEC3
//   instr            instruction register
//   fetch..exec3     one-hot phase strobes
//   busy             sequencer not idle
//   instr_done       one-cycle pulse after an instruction completes
//   retired          completed-instruction count
//
// Modports: master drives control/ROM/decoder inputs, slave is the sequencer.
interface phase_sequencer_if #(
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W_DEFAULT,
  parameter int unsigned CNT_W   = cpu_pkg::CNT_W_DEFAULT
);

  logic               run;
  logic               step;
  logic [INSTR_W-1:0] rom_q;
  logic               extra;
  logic               extra2;
  logic [INSTR_W-1:0] instr;
  logic               fetch;
  logic               exec1;
  logic               exec2;
  logic               exec3;
  logic               busy;
  logic               instr_done;
  logic [CNT_W-1:0]   retired;

  modport master (
    output run,
    output step,
    output rom_q,
    output extra,
    output extra2,
    input  instr,
    input  fetch,
    input  exec1,
    input  exec2,
    input  exec3,
    input  busy,
    input  instr_done,
    input  retired
  );

  modport slave (
    input  run,
    input  step,
    input  rom_q,
    input  extra,
    input  extra2,
    output instr,
    output fetch,
    output exec1,
    output exec2,
    output exec3,
    output busy,
    output instr_done,
    output retired
  );

endinterface

// File: rtl/retire_counter.sv
// Retired-instruction counter: increments on en, wraps modulo 2^CNT_W,
// synchronous active-low clear.
//
// Ports:
//   clk      clock
//   clear_n  synchronous active-low clear
//   en       count enable (one per completed instruction)
//   count    current count
module retire_counter #(
  parameter int unsigned CNT_W = cpu_pkg::CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Natural wrap from all-ones to zero, no overflow flag.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/phase_sequencer.sv
// Control-phase sequencer for the 16-bit CPU. Latches the fetched word into
// the instruction register and steps FETCH -> EXEC1 [-> EXEC2 [-> EXEC3]],
// with the decoder's extra/extra2 flags selecting the instruction length.
// Continuous run or single-step from idle; a retired-instruction counter and
// a completion pulse are provided for debug.
//
// Ports:
//   clk      clock, all state on rising edge
//   reset_n  synchronous active-low reset
//   bus      phase_sequencer_if slave modport (see interface for signals)
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input logic                clk,
  input logic                reset_n,
  phase_sequencer_if.slave   bus
);

  phase_t             state_q;
  phase_t             state_d;
  logic [INSTR_W-1:0] instr_q;
  strobes_t           strobes_q;
  logic               busy_q;
  logic               done_q;
  logic               end_instr;
  logic               load_ir;

  // Next-state logic. end_instr marks the edge leaving the last exec phase;
  // it then overrides the next state so a dropped run finishes the current
  // instruction and parks in idle instead of aborting.
  always_comb begin
    state_d   = state_q;
    end_instr = 1'b0;
    load_ir   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // run alone or step alone both start a fetch; both together behave as run.
        if (bus.run || bus.step) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StExec1;
        load_ir = 1'b1;
      end
      StExec1: begin
        if (bus.extra) begin
          state_d = StExec2;
        end else begin
          end_instr = 1'b1;
        end
      end
      StExec2: begin
        if (bus.extra2) begin
          state_d = StExec3;
        end else begin
          end_instr = 1'b1;
        end
      end
      StExec3: begin
        end_instr = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (end_instr) begin
      state_d = bus.run ? StFetch : StIdle;
    end
  end

  // Strobes, busy and the completion pulse are registered from the next
  // state so they change cleanly on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      strobes_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      strobes_q <= phase_decode(state_d);
      busy_q    <= (state_d != StIdle);
      done_q    <= end_instr;
      if (load_ir) begin
        instr_q <= bus.rom_q;
      end
    end
  end

  logic [CNT_W-1:0] retired_cnt;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk     (clk),
    .clear_n (reset_n),
    .en      (end_instr),
    .count   (retired_cnt)
  );

  assign bus.instr      = instr_q;
  assign bus.fetch      = strobes_q.fetch;
  assign bus.exec1      = strobes_q.exec1;
  assign bus.exec2      = strobes_q.exec2;
  assign bus.exec3      = strobes_q.exec3;
  assign bus.busy       = busy_q;
  assign bus.instr_done = done_q;
  assign bus.retired    = retired_cnt;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer. Each directed vector applies inputs for one
// clock and pushes the hand-computed outputs expected after that edge; an
// independent monitor pops and compares them on the falling edge.
module tb_phase_sequencer;

  localparam int unsigned IW = 16;
  localparam int unsigned CW = 4;

  // {busy, fetch, exec1, exec2, exec3}
  localparam logic [4:0] PI = 5'b00000;
  localparam logic [4:0] PF = 5'b11000;
  localparam logic [4:0] P1 = 5'b10100;
  localparam logic [4:0] P2 = 5'b10010;
  localparam logic [4:0] P3 = 5'b10001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  phase_sequencer_if #(.INSTR_W(IW), .CNT_W(CW)) bus ();

  phase_sequencer #(
    .INSTR_W (IW),
    .CNT_W   (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          tag;
    logic [4:0]  ph;
    logic [15:0] ins;
    logic [3:0]  ret;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic rn, input logic r, input logic s, input logic [15:0] rom,
                       input logic ex, input logic ex2, input logic [4:0] ph,
                       input logic [15:0] ins, input logic [3:0] ret, input logic dn);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n    = rn;
    bus.run    = r;
    bus.step   = s;
    bus.rom_q  = rom;
    bus.extra  = ex;
    bus.extra2 = ex2;
    e.tag = cyc + 1;
    e.ph  = ph;
    e.ins = ins;
    e.ret = ret;
    e.dn  = dn;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] act;
    act = {bus.busy, bus.fetch, bus.exec1, bus.exec2, bus.exec3};
    if (exp_q.size() > 0) begin
      if (exp_q[0].tag < cyc) begin
        e = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL stale_expect cyc=%0d got tag=%0d required tag=%0d", cyc, e.tag, cyc);
      end else if (exp_q[0].tag == cyc) begin
        e = exp_q.pop_front();
        tests++;
        if (act !== e.ph) begin
          fails++;
          $display("FAIL phase cyc=%0d got=%b required=%b", cyc, act, e.ph);
        end
        tests++;
        if (bus.instr !== e.ins) begin
          fails++;
          $display("FAIL instr cyc=%0d got=%h required=%h", cyc, bus.instr, e.ins);
        end
        tests++;
        if (bus.retired !== e.ret) begin
          fails++;
          $display("FAIL retired cyc=%0d got=%0d required=%0d", cyc, bus.retired, e.ret);
        end
        tests++;
        if (bus.instr_done !== e.dn) begin
          fails++;
          $display("FAIL instr_done cyc=%0d got=%b required=%b", cyc, bus.instr_done, e.dn);
        end
      end
    end
  end

  initial begin
    bus.run    = 1'b0;
    bus.step   = 1'b0;
    bus.rom_q  = '0;
    bus.extra  = 1'b0;
    bus.extra2 = 1'b0;

    // Reset
    drive(0, 0, 0, 16'h0000, 0, 0, PI, 16'h0000, 0, 0);
    drive(0, 0, 0, 16'h0000, 0, 0, PI, 16'h0000, 0, 0);

    // ldn, 4-cycle instruction under run
    drive(1, 1, 0, 16'h4000, 1, 1, PF, 16'h0000, 0, 0);
    drive(1, 1, 0, 16'h4000, 1, 1, P1, 16'h4000, 0, 0);
    drive(1, 1, 0, 16'h4000, 1, 1, P2, 16'h4000, 0, 0);
    drive(1, 1, 0, 16'h4000, 1, 1, P3, 16'h4000, 0, 0);
    drive(1, 1, 0, 16'h8000, 0, 1, PF, 16'h4000, 1, 1);

    // ldi back to back; extra2 high in EXEC1 must be ignored
    drive(1, 1, 0, 16'h8000, 0, 1, P1, 16'h8000, 1, 0);
    drive(1, 1, 0, 16'h8000, 0, 1, PF, 16'h8000, 2, 1);
    drive(1, 1, 0, 16'h8000, 0, 1, P1, 16'h8000, 2, 0);
    drive(1, 1, 0, 16'h8000, 0, 1, PF, 16'h8000, 3, 1);
    drive(1, 1, 0, 16'h8000, 0, 1, P1, 16'h8000, 3, 0);
    drive(1, 0, 0, 16'h8000, 0, 1, PI, 16'h8000, 4, 1);
    drive(1, 0, 0, 16'h8000, 0, 1, PI, 16'h8000, 4, 0);

    // Single step of lda (3 cycles)
    drive(1, 0, 1, 16'h1234, 1, 0, PF, 16'h8000, 4, 0);
    drive(1, 0, 0, 16'h1234, 1, 0, P1, 16'h1234, 4, 0);
    drive(1, 0, 0, 16'h1234, 1, 0, P2, 16'h1234, 4, 0);
    drive(1, 0, 0, 16'h1234, 1, 0, PI, 16'h1234, 5, 1);
    drive(1, 0, 0, 16'h1234, 1, 0, PI, 16'h1234, 5, 0);
    drive(1, 0, 0, 16'h1234, 1, 0, PI, 16'h1234, 5, 0);

    // run dropped in EXEC2; step in EXEC3 ignored
    drive(1, 1, 0, 16'h4000, 1, 1, PF, 16'h1234, 5, 0);
    drive(1, 1, 0, 16'h4000, 1, 1, P1, 16'h4000, 5, 0);
    drive(1, 1, 0, 16'h4000, 1, 1, P2, 16'h4000, 5, 0);
    drive(1, 0, 0, 16'h4000, 1, 1, P3, 16'h4000, 5, 0);
    drive(1, 0, 1, 16'h4000, 1, 1, PI, 16'h4000, 6, 1);
    drive(1, 0, 0, 16'h4000, 1, 1, PI, 16'h4000, 6, 0);

    // Reset during EXEC2, then restart
    drive(1, 1, 0, 16'h5555, 1, 1, PF, 16'h4000, 6, 0);
    drive(1, 1, 0, 16'h5555, 1, 1, P1, 16'h5555, 6, 0);
    drive(1, 1, 0, 16'h5555, 1, 1, P2, 16'h5555, 6, 0);
    drive(0, 1, 0, 16'h5555, 1, 1, PI, 16'h0000, 0, 0);
    drive(1, 1, 0, 16'h8000, 0, 0, PF, 16'h0000, 0, 0);

    // 16 one-exec instructions: 4-bit counter wraps 15 -> 0
    drive(1, 1, 0, 16'h8000, 0, 0, P1, 16'h8000, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      drive(1, 1, 0, 16'h8000, 0, 0, PF, 16'h8000, 4'(i), 1);
      drive(1, 1, 0, 16'h8000, 0, 0, P1, 16'h8000, 4'(i), 0);
    end
    drive(1, 0, 0, 16'h8000, 0, 0, PI, 16'h8000, 0, 1);
    drive(1, 0, 0, 16'h8000, 0, 0, PI, 16'h8000, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Control-phase state machine for the 16-bit CPU, sitting directly upstream of the instruction decoder. It latches the fetched instruction word into the instruction register and drives the one-hot phase strobes `fetch`, `exec1`, `exec2` and `exec3`. It uses the decoder's `extra` and `extra2` flags to choose between 1, 2 or 3 execute phases per instruction. It also provides run/single-step control and a retired-instruction counter for debug.

## Interface
Parameters:
- `INSTR_W`, default 16: instruction register width.
- `CNT_W`, default 16: retired-instruction counter width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `run`  in  1  level; 1 = execute continuously.
- `step`  in  1  single-cycle pulse; executes one instruction from IDLE.
- `rom_q`  in  INSTR_W  instruction word from program ROM; valid by the end of the FETCH cycle.
- `extra`  in  1  from decoder; instruction needs EXEC2.
- `extra2`  in  1  from decoder; instruction needs EXEC3.
- `instr`  out  INSTR_W  instruction register, feeds the decoder.
- `fetch`, `exec1`, `exec2`, `exec3`  out  1 each  registered one-hot phase strobes.
- `busy`  out  1  high in any state except IDLE.
- `instr_done`  out  1  one-cycle pulse in the cycle after the last exec phase of an instruction.
- `retired`  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, FETCH, EXEC1, EXEC2, EXEC3. Phase outputs are a registered decode of the state; all are 0 in IDLE.
- IDLE:
  - `run`=1 → FETCH.
  - `run`=0 and `step`=1 → FETCH.
  - Otherwise stay in IDLE.
- FETCH → EXEC1, unconditionally. On this edge `instr` ← `rom_q`. `instr` is unchanged in all other transitions.
- EXEC1:
  - `extra`=1 → EXEC2.
  - `extra`=0 → END.
- EXEC2:
  - `extra2`=1 → EXEC3.
  - `extra2`=0 → END.
- EXEC3 → END.
- END (a transition, not a state):
  - Next state is FETCH if `run`=1, else IDLE.
  - `retired` increments by 1.
  - `instr_done` asserts for the following cycle.
- `extra` and `extra2` are sampled only in EXEC1 and EXEC2 respectively. `extra2` is ignored in EXEC1.
- `step` is ignored outside IDLE. When `run` and `step` are both high, the result is the same as `run` alone.
- Dropping `run` mid-instruction finishes the current instruction, then enters IDLE. No instruction is ever aborted except by reset.
- Reset, asserted in any cycle, takes effect on the next edge:
  - state → IDLE;
  - `instr`, `retired`, `instr_done`, `busy` and all phase outputs → 0.
  - The FSM leaves IDLE only on the first edge with `reset_n`=1.

## Timing
- Instruction length is 2, 3 or 4 cycles (FETCH plus 1–3 EXEC cycles). There are no bubbles between back-to-back instructions while `run`=1.
- From IDLE, the first FETCH appears 1 cycle after the edge that samples `run` or `step` high.
- `instr` is valid from the first cycle of EXEC1 through the last exec phase. The decoder outputs are therefore combinational on a stable IR.
- Exactly one phase strobe is high in every non-IDLE cycle.
- `retired` updates on the same edge that leaves the last exec phase. `instr_done` is high during the cycle after that edge, which is the next FETCH, or IDLE.
- Counter wrap: 2^CNT_W−1 + 1 → 0, with no flag.

## Structure
- Shared package `cpu_pkg`:
  - `phase_t` enum {IDLE, FETCH, EXEC1, EXEC2, EXEC3};
  - `INSTR_W` default constant.
- Single FSM module plus IR register inline.
- One natural sub-module: `retire_counter` (enable, synchronous active-low clear, wrap).

## Test plan
- Reset then `run`=1 with `rom_q`=16'h4000 (ldn, `extra`=`extra2`=1) → phases FETCH, E1, E2, E3, FETCH; `instr`=16'h4000 from E1; `retired`=1 after E3.
- `run`=1 with ldi (`rom_q`=16'h8000, `extra`=0) repeated → 2-cycle cadence F, E1, F, E1; `retired` counts 1, 2, 3 each E1 exit.
- `run`=0, single `step` pulse in IDLE with lda (`extra`=1, `extra2`=0) → IDLE, F, E1, E2, IDLE; `instr_done` high for exactly 1 cycle; `retired`=1; further idle cycles leave it unchanged.
- `run` deasserted during EXEC2 of a 4-cycle instruction → EXEC3 completes, then IDLE; `step` pulsed during EXEC3 is ignored.
- `reset_n`=0 for 1 cycle during EXEC2 → next cycle IDLE, `instr`=0, `retired`=0, all strobes 0; restart with `run`=1 gives FETCH 1 cycle after release.
- CNT_W=4: run 16 one-exec instructions → `retired` wraps 15→0; `instr_done` still pulses on the wrapping instruction.
